// File: rtl/clock_adjust_ctrl.sv
// Front-panel adjust sequencer: MODE steps a one-hot field select, UP/DOWN become hold-to-repeat pulses.
// All outputs registered (one cycle after the input edge). Define ADJ_TIMEOUT_EN for idle return to RUN.
module clock_adjust_ctrl #(
  parameter int HOLD_CYCLES    = 50_000_000,
  parameter int REPEAT_CYCLES  = 10_000_000,
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [5:0] adj_sel,
  output logic       adj_up,
  output logic       adj_down,
  output logic       count_pause,
  output logic       adj_active
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_CYCLES);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

  if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("clock_adjust_ctrl: cycle parameters out of range");
  end

  typedef enum logic [2:0] {
    S_RUN, S_SEC, S_MIN, S_HOUR, S_DAY, S_MON, S_YEAR
  } state_t;

  state_t        state_q, state_d;
  logic          prev_mode_q, prev_up_q, prev_down_q;
  logic          hold_up_q, hold_up_d;
  logic          hold_down_q, hold_down_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic [5:0]    sel_q, sel_d;
  logic          up_q, up_d;
  logic          down_q, down_d;
  logic          pause_q, pause_d;

  logic rise_mode, up_only, down_only, prev_up_only, prev_down_only;
  logic in_adj, fire;

`ifdef ADJ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] idle_cnt_q, idle_cnt_d;
`endif

  always_comb begin
    rise_mode      = btn_mode & ~prev_mode_q;
    up_only        = btn_up & ~btn_down;
    down_only      = btn_down & ~btn_up;
    prev_up_only   = prev_up_q & ~prev_down_q;
    prev_down_only = prev_down_q & ~prev_up_q;
    in_adj         = (state_q != S_RUN);

    state_d     = state_q;
    hold_up_d   = 1'b0;
    hold_down_d = 1'b0;
    hold_cnt_d  = '0;
    rep_cnt_d   = '0;
    up_d        = 1'b0;
    down_d      = 1'b0;
    fire        = 1'b0;

    // A mode edge wins over any UP/DOWN activity and drops the repeat context.
    if (rise_mode) begin
      case (state_q)
        S_RUN:   state_d = S_SEC;
        S_SEC:   state_d = S_MIN;
        S_MIN:   state_d = S_HOUR;
        S_HOUR:  state_d = S_DAY;
        S_DAY:   state_d = S_MON;
        S_MON:   state_d = S_YEAR;
        default: state_d = S_RUN;
      endcase
    end else if (in_adj) begin
      if (up_only && !prev_up_only) begin
        hold_up_d = 1'b1;
        up_d      = 1'b1;
      end else if (down_only && !prev_down_only) begin
        hold_down_d = 1'b1;
        down_d      = 1'b1;
      end else if ((hold_up_q && up_only) || (hold_down_q && down_only)) begin
        hold_up_d   = hold_up_q;
        hold_down_d = hold_down_q;
        // First pulse after HOLD_CYCLES, then every REPEAT_CYCLES once saturated.
        if (hold_cnt_q != HOLD_SAT) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
          fire       = (hold_cnt_q == HOLD_LAST);
        end else begin
          hold_cnt_d = hold_cnt_q;
          if (rep_cnt_q == REP_LAST) begin
            fire = 1'b1;
          end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
        end
        up_d   = fire & hold_up_q;
        down_d = fire & hold_down_q;
      end
    end

`ifdef ADJ_TIMEOUT_EN
    idle_cnt_d = '0;
    if (in_adj && !btn_mode && !btn_up && !btn_down) begin
      if (idle_cnt_q == IDLE_LAST) begin
        state_d = S_RUN;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end
`endif

    case (state_d)
      S_SEC:   sel_d = 6'b000001;
      S_MIN:   sel_d = 6'b000010;
      S_HOUR:  sel_d = 6'b000100;
      S_DAY:   sel_d = 6'b001000;
      S_MON:   sel_d = 6'b010000;
      S_YEAR:  sel_d = 6'b100000;
      default: sel_d = 6'b000000;
    endcase
    pause_d = (state_d != S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      prev_mode_q <= 1'b0;
      prev_up_q   <= 1'b0;
      prev_down_q <= 1'b0;
      hold_up_q   <= 1'b0;
      hold_down_q <= 1'b0;
      hold_cnt_q  <= '0;
      rep_cnt_q   <= '0;
      sel_q       <= '0;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      pause_q     <= 1'b0;
`ifdef ADJ_TIMEOUT_EN
      idle_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      prev_mode_q <= btn_mode;
      prev_up_q   <= btn_up;
      prev_down_q <= btn_down;
      hold_up_q   <= hold_up_d;
      hold_down_q <= hold_down_d;
      hold_cnt_q  <= hold_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      sel_q       <= sel_d;
      up_q        <= up_d;
      down_q      <= down_d;
      pause_q     <= pause_d;
`ifdef ADJ_TIMEOUT_EN
      idle_cnt_q  <= idle_cnt_d;
`endif
    end
  end

  assign adj_sel     = sel_q;
  assign adj_up      = up_q;
  assign adj_down    = down_q;
  assign count_pause = pause_q;
  assign adj_active  = pause_q;

endmodule

// File: tb/tb_clock_adjust_ctrl.sv
// Bench for clock_adjust_ctrl: directed scenarios plus random button bursts against a duration-based model.
module tb_clock_adjust_ctrl;
  localparam int HOLD    = 8;
  localparam int REPEAT  = 4;
  localparam int TIMEOUT = 32;

  logic       clk = 1'b0;
  logic       rst, btn_mode, btn_up, btn_down;
  logic [5:0] adj_sel;
  logic       adj_up, adj_down, count_pause, adj_active;

  clock_adjust_ctrl #(
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REPEAT), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .adj_sel(adj_sel), .adj_up(adj_up), .adj_down(adj_down),
    .count_pause(count_pause), .adj_active(adj_active)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int up_pulses, dn_pulses;

  // Reference: field index 0..6, active direction, cycles since the detecting edge.
  int m_st, m_dir, m_t, m_idle;
  bit m_pu, m_pd, m_pm, m_up, m_dn;

  logic [5:0] sel_tab [7] = '{6'b000001, 6'b000010, 6'b000100, 6'b001000,
                              6'b010000, 6'b100000, 6'b000000};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit rm, uo, dno, puo, pdo, fire;
    if (rst) begin
      m_st = 0; m_dir = 0; m_t = 0; m_idle = 0;
      m_pu = 0; m_pd = 0; m_pm = 0; m_up = 0; m_dn = 0;
      return;
    end
    rm  = btn_mode && !m_pm;
    uo  = btn_up && !btn_down;
    dno = btn_down && !btn_up;
    puo = m_pu && !m_pd;
    pdo = m_pd && !m_pu;
    m_up = 0; m_dn = 0;
    if (rm) begin
      m_st  = (m_st + 1) % 7;
      m_dir = 0;
    end else if (m_st != 0) begin
      if (uo && !puo) begin
        m_dir = 1; m_t = 0; m_up = 1;
      end else if (dno && !pdo) begin
        m_dir = 2; m_t = 0; m_dn = 1;
      end else if ((m_dir == 1 && uo) || (m_dir == 2 && dno)) begin
        m_t++;
        fire = (m_t == HOLD) || (m_t > HOLD && ((m_t - HOLD) % REPEAT) == 0);
        if (m_dir == 1) m_up = fire;
        else            m_dn = fire;
      end else begin
        m_dir = 0;
      end
    end else begin
      m_dir = 0;
    end
`ifdef ADJ_TIMEOUT_EN
    if (m_st == 0 || btn_mode || btn_up || btn_down) begin
      m_idle = 0;
    end else begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        m_st = 0; m_idle = 0; m_dir = 0;
      end
    end
`endif
    m_pu = btn_up; m_pd = btn_down; m_pm = btn_mode;
  endtask

  task automatic step();
    logic [5:0] exp_sel;
    @(posedge clk);
    model_edge();
    #1;
    exp_sel = (m_st == 0) ? 6'd0 : 6'(1 << (m_st - 1));
    chk("adj_sel", adj_sel, exp_sel);
    chk("adj_up", adj_up, m_up);
    chk("adj_down", adj_down, m_dn);
    chk("count_pause", count_pause, m_st != 0);
    chk("adj_active", adj_active, m_st != 0);
    if (adj_up === 1'b1) up_pulses++;
    if (adj_down === 1'b1) dn_pulses++;
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    repeat (3) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic enter_day();
    repeat (3) press_mode();
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
  endtask

  initial begin
    rst = 1'b1; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    up_pulses = 0; dn_pulses = 0;
    step();
    chk("rst_sel", adj_sel, 0);
    chk("rst_pause", count_pause, 0);
    rst = 1'b0;
    step();

    // Walk the field select through a full cycle.
    for (int i = 0; i < 7; i++) begin
      btn_mode = 1'b1;
      step();
      chk("mode_sel", adj_sel, sel_tab[i]);
      chk("mode_pause", count_pause, i < 6);
      btn_mode = 1'b0;
      repeat (3) step();
    end

    // SEC: hold UP for 20 cycles -> pulses at offsets 1, 9, 13, 17.
    press_mode();
    up_pulses = 0; dn_pulses = 0;
    btn_up = 1'b1;
    repeat (20) step();
    btn_up = 1'b0;
    repeat (6) step();
    chk("sec_up_count", up_pulses, 4);
    chk("sec_down_count", dn_pulses, 0);

    // MIN: UP, then both, then DOWN alone.
    press_mode();
    up_pulses = 0; dn_pulses = 0;
    btn_up = 1'b1;
    repeat (3) step();
    btn_down = 1'b1;
    repeat (10) step();
    btn_up = 1'b0;
    repeat (3) step();
    btn_down = 1'b0;
    repeat (3) step();
    chk("min_up_count", up_pulses, 1);
    chk("min_down_count", dn_pulses, 1);

    // Back to RUN, then UP/DOWN must be ignored.
    repeat (5) press_mode();
    up_pulses = 0; dn_pulses = 0;
    for (int i = 0; i < 20; i++) begin
      btn_up   = 1'($urandom_range(0, 1));
      btn_down = 1'($urandom_range(0, 1));
      step();
    end
    btn_up = 1'b0; btn_down = 1'b0;
    step();
    chk("run_up_count", up_pulses, 0);
    chk("run_down_count", dn_pulses, 0);
    chk("run_sel", adj_sel, 0);

    // HOUR: reset in the middle of a DOWN hold.
    repeat (3) press_mode();
    btn_down = 1'b1;
    repeat (6) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("hr_rst_sel", adj_sel, 0);
    chk("hr_rst_up", adj_up, 0);
    chk("hr_rst_down", adj_down, 0);
    chk("hr_rst_pause", count_pause, 0);
    chk("hr_rst_active", adj_active, 0);
    dn_pulses = 0;
    repeat (10) step();
    chk("hr_held_run_down", dn_pulses, 0);
    btn_down = 1'b0;
    do_reset();

    // Idle behaviour in DAY.
    enter_day();
`ifdef ADJ_TIMEOUT_EN
    repeat (31) step();
    chk("to_still_day", adj_sel, 6'b001000);
    step();
    chk("to_run_sel", adj_sel, 0);
    chk("to_run_pause", count_pause, 0);
    do_reset();
    enter_day();
    repeat (19) step();
    btn_up = 1'b1;
    step();
    btn_up = 1'b0;
    repeat (31) step();
    chk("to_restart_day", adj_sel, 6'b001000);
    step();
    chk("to_restart_run", adj_sel, 0);
`else
    repeat (100) step();
    chk("no_timeout_day", adj_sel, 6'b001000);
    chk("no_timeout_pause", count_pause, 1);
`endif
    do_reset();

    // Random bursts of button activity.
    for (int b = 0; b < 60; b++) begin
      int r, len;
      r        = int'($urandom_range(0, 99));
      len      = int'($urandom_range(1, 16));
      btn_up   = 1'($urandom_range(0, 1));
      btn_down = ($urandom_range(0, 3) == 0);
      rst      = (r < 3);
      btn_mode = (r >= 3 && r < 30);
      step();
      rst      = 1'b0;
      btn_mode = 1'b0;
      repeat (len) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
